// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter for a single-port register memory,
// with read-data return routing and a zero-fill CLEAR sweep.
module mem_port_arbiter #(
  parameter int WIDTH = 8,
  parameter int PSIZE = 4,
  parameter int DEPTH = 2**PSIZE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_req,
  input  logic             a_wr,
  input  logic [PSIZE-1:0] a_addr,
  input  logic [WIDTH-1:0] a_wdata,
  output logic             a_gnt,
  output logic             a_rvalid,
  input  logic             b_req,
  input  logic             b_wr,
  input  logic [PSIZE-1:0] b_addr,
  input  logic [WIDTH-1:0] b_wdata,
  output logic             b_gnt,
  output logic             b_rvalid,
  output logic [WIDTH-1:0] rdata,
  input  logic             clr_start,
  output logic             clr_busy,
  output logic             mem_wr,
  output logic             mem_rd,
  output logic [PSIZE-1:0] mem_wr_addr,
  output logic [PSIZE-1:0] mem_rd_addr,
  output logic [WIDTH-1:0] mem_data,
  input  logic [WIDTH-1:0] mem_rdata
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t           state, state_nxt;
  logic [PSIZE-1:0] clr_cnt, clr_cnt_nxt;
  logic             last_gnt_b, last_gnt_b_nxt;
  logic             a_vld_p1, b_vld_p1;
  logic             sel_wr;
  logic [PSIZE-1:0] sel_addr;
  logic [WIDTH-1:0] sel_wdata;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      clr_cnt    <= '0;
      last_gnt_b <= 1'b1;
      a_vld_p1   <= 1'b0;
      b_vld_p1   <= 1'b0;
    end else begin
      state      <= state_nxt;
      clr_cnt    <= clr_cnt_nxt;
      last_gnt_b <= last_gnt_b_nxt;
      a_vld_p1   <= a_gnt & ~a_wr;
      b_vld_p1   <= b_gnt & ~b_wr;
    end
  end

  always_comb begin
    state_nxt      = state;
    clr_cnt_nxt    = clr_cnt;
    last_gnt_b_nxt = last_gnt_b;
    a_gnt          = 1'b0;
    b_gnt          = 1'b0;
    clr_busy       = 1'b0;
    mem_wr         = 1'b0;
    mem_rd         = 1'b0;
    mem_wr_addr    = '0;
    mem_rd_addr    = '0;
    mem_data       = '0;
    sel_wr         = 1'b0;
    sel_addr       = '0;
    sel_wdata      = '0;
    if (rst_n) begin
      case (state)
        IDLE: begin
          if (clr_start) begin
            state_nxt   = CLEAR;
            clr_cnt_nxt = '0;
          end else begin
            // A wins unless B is also requesting and A was served last
            a_gnt = a_req & (~b_req | last_gnt_b);
            b_gnt = b_req & ~a_gnt;
            if (a_gnt) begin
              sel_wr         = a_wr;
              sel_addr       = a_addr;
              sel_wdata      = a_wdata;
              last_gnt_b_nxt = 1'b0;
            end else if (b_gnt) begin
              sel_wr         = b_wr;
              sel_addr       = b_addr;
              sel_wdata      = b_wdata;
              last_gnt_b_nxt = 1'b1;
            end
            if (a_gnt | b_gnt) begin
              if (sel_wr) begin
                mem_wr      = 1'b1;
                mem_wr_addr = sel_addr;
                mem_data    = sel_wdata;
              end else begin
                mem_rd      = 1'b1;
                mem_rd_addr = sel_addr;
              end
            end
          end
        end
        CLEAR: begin
          clr_busy    = 1'b1;
          mem_wr      = 1'b1;
          mem_wr_addr = clr_cnt;
          clr_cnt_nxt = clr_cnt + PSIZE'(1);
          if (clr_cnt == PSIZE'(DEPTH-1)) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // ---- read return stage (one cycle after the read grant) ----
  assign a_rvalid = a_vld_p1;
  assign b_rvalid = b_vld_p1;
  assign rdata    = rst_n ? mem_rdata : '0;

  a_single_op: assert property (@(posedge clk) disable iff (!rst_n) !(mem_wr && mem_rd));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural half-swapping
// register memory; inputs change just after posedge, outputs sampled on negedge.
module tb_mem_port_arbiter;

  localparam int WIDTH = 8;
  localparam int PSIZE = 4;
  localparam int DEPTH = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             a_req, a_wr, b_req, b_wr, clr_start;
  logic [PSIZE-1:0] a_addr, b_addr;
  logic [WIDTH-1:0] a_wdata, b_wdata;
  logic             a_gnt, a_rvalid, b_gnt, b_rvalid, clr_busy;
  logic             mem_wr, mem_rd;
  logic [PSIZE-1:0] mem_wr_addr, mem_rd_addr;
  logic [WIDTH-1:0] mem_data, mem_rdata, rdata;

  logic [WIDTH-1:0] mem [DEPTH];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.WIDTH(WIDTH), .PSIZE(PSIZE), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_wr(a_wr), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid),
    .b_req(b_req), .b_wr(b_wr), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid),
    .rdata(rdata), .clr_start(clr_start), .clr_busy(clr_busy),
    .mem_wr(mem_wr), .mem_rd(mem_rd),
    .mem_wr_addr(mem_wr_addr), .mem_rd_addr(mem_rd_addr),
    .mem_data(mem_data), .mem_rdata(mem_rdata)
  );

  // Memory model: cleared by reset, registered read, nibble swap on upper half
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      mem_rdata <= '0;
    end else begin
      if (mem_wr) mem[mem_wr_addr] <= mem_data;
      if (mem_rd) mem_rdata <= (mem_rd_addr >= PSIZE'(DEPTH/2)) ?
                               {mem[mem_rd_addr][3:0], mem[mem_rd_addr][7:4]} :
                               mem[mem_rd_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    a_req = 0; a_wr = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_wr = 0; b_addr = '0; b_wdata = '0;
    clr_start = 0;
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    a_req = 1;
    @(negedge clk);
    chk("rst_a_gnt", 32'(a_gnt), 0);
    chk("rst_mem_wr", 32'(mem_wr), 0);
    chk("rst_mem_rd", 32'(mem_rd), 0);
    tick(); tick();
    rst_n = 1;
    a_req = 0;
    @(negedge clk);
    chk("rst_a_rvalid", 32'(a_rvalid), 0);
    chk("rst_b_rvalid", 32'(b_rvalid), 0);
    chk("rst_clr_busy", 32'(clr_busy), 0);
    tick();

    // A write 3 <- 0x5A then read 3
    a_req = 1; a_wr = 1; a_addr = 4'd3; a_wdata = 8'h5A;
    @(negedge clk);
    chk("t1_wr_gnt", 32'(a_gnt), 1);
    chk("t1_mem_wr", 32'(mem_wr), 1);
    chk("t1_mem_rd", 32'(mem_rd), 0);
    chk("t1_wr_addr", 32'(mem_wr_addr), 3);
    chk("t1_wr_data", 32'(mem_data), 32'h5A);
    tick();
    a_wr = 0;
    @(negedge clk);
    chk("t1_rd_gnt", 32'(a_gnt), 1);
    chk("t1_mem_rd", 32'(mem_rd), 1);
    chk("t1_rd_addr", 32'(mem_rd_addr), 3);
    chk("t1_rd_wr_addr", 32'(mem_wr_addr), 0);
    chk("t1_early_rvalid", 32'(a_rvalid), 0);
    tick();
    a_req = 0;
    @(negedge clk);
    chk("t1_a_rvalid", 32'(a_rvalid), 1);
    chk("t1_b_rvalid", 32'(b_rvalid), 0);
    chk("t1_rdata", 32'(rdata), 32'h5A);
    tick();

    // B write 0 <- 0x11 so that B was served last
    b_req = 1; b_wr = 1; b_addr = 4'd0; b_wdata = 8'h11;
    @(negedge clk);
    chk("t2_b_wr_gnt", 32'(b_gnt), 1);
    tick();
    b_req = 0; b_wr = 0;

    // Both read every cycle: A,B,A,B
    a_req = 1; a_wr = 0; a_addr = 4'd3;
    b_req = 1; b_wr = 0; b_addr = 4'd0;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin a_req = 0; b_req = 0; end
      @(negedge clk);
      if (i < 4) begin
        chk($sformatf("t2_a_gnt%0d", i), 32'(a_gnt), 32'(i % 2 == 0));
        chk($sformatf("t2_b_gnt%0d", i), 32'(b_gnt), 32'(i % 2 == 1));
      end
      if (i > 0) begin
        chk($sformatf("t2_a_rv%0d", i), 32'(a_rvalid), 32'((i-1) % 2 == 0));
        chk($sformatf("t2_b_rv%0d", i), 32'(b_rvalid), 32'((i-1) % 2 == 1));
        chk($sformatf("t2_rdata%0d", i), 32'(rdata), ((i-1) % 2 == 0) ? 32'h5A : 32'h11);
      end
      tick();
    end

    // B write 9 <- 0x3C, A read 9 returns swapped 0xC3
    b_req = 1; b_wr = 1; b_addr = 4'd9; b_wdata = 8'h3C;
    @(negedge clk);
    chk("t3_b_gnt", 32'(b_gnt), 1);
    tick();
    b_req = 0; b_wr = 0;
    a_req = 1; a_wr = 0; a_addr = 4'd9;
    @(negedge clk);
    chk("t3_a_gnt", 32'(a_gnt), 1);
    tick();
    a_req = 0;
    @(negedge clk);
    chk("t3_a_rvalid", 32'(a_rvalid), 1);
    chk("t3_rdata", 32'(rdata), 32'hC3);
    tick();

    // Fill with 0xFF, CLEAR sweep, read back zeros
    for (int i = 0; i < DEPTH; i++) begin
      a_req = 1; a_wr = 1; a_addr = PSIZE'(i); a_wdata = 8'hFF;
      @(negedge clk);
      chk($sformatf("t4_fill%0d", i), 32'(a_gnt), 1);
      tick();
    end
    idle_inputs();
    clr_start = 1;
    @(negedge clk);
    chk("t4_start_busy", 32'(clr_busy), 0);
    chk("t4_start_mem_wr", 32'(mem_wr), 0);
    tick();
    clr_start = 0;
    for (int i = 0; i < DEPTH; i++) begin
      clr_start = (i == 5);
      @(negedge clk);
      chk($sformatf("t4_busy%0d", i), 32'(clr_busy), 1);
      chk($sformatf("t4_wr%0d", i), 32'(mem_wr), 1);
      chk($sformatf("t4_addr%0d", i), 32'(mem_wr_addr), 32'(i));
      chk($sformatf("t4_data%0d", i), 32'(mem_data), 0);
      tick();
    end
    clr_start = 0;
    @(negedge clk);
    chk("t4_busy_end", 32'(clr_busy), 0);
    for (int i = 0; i <= DEPTH; i++) begin
      if (i < DEPTH) begin a_req = 1; a_wr = 0; a_addr = PSIZE'(i); end
      else a_req = 0;
      @(negedge clk);
      if (i > 0) begin
        chk($sformatf("t4_rv%0d", i-1), 32'(a_rvalid), 1);
        chk($sformatf("t4_rd%0d", i-1), 32'(rdata), 0);
      end
      tick();
    end

    // clr_start with a_req held: grant only once busy falls
    a_req = 1; a_wr = 0; a_addr = 4'd3; clr_start = 1;
    @(negedge clk);
    chk("t5_start_gnt", 32'(a_gnt), 0);
    tick();
    clr_start = 0;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      chk($sformatf("t5_gnt%0d", i), 32'(a_gnt), 0);
      tick();
    end
    @(negedge clk);
    chk("t5_busy_fell", 32'(clr_busy), 0);
    chk("t5_gnt_after", 32'(a_gnt), 1);
    tick();
    a_req = 0;

    // Reset at clr_cnt=7 aborts the sweep; first tie then goes to A
    clr_start = 1;
    tick();
    clr_start = 0;
    for (int i = 0; i < 7; i++) tick();
    @(negedge clk);
    chk("t6_addr7", 32'(mem_wr_addr), 7);
    tick();
    rst_n = 0;
    @(negedge clk);
    chk("t6_rst_busy", 32'(clr_busy), 0);
    chk("t6_rst_mem_wr", 32'(mem_wr), 0);
    tick();
    rst_n = 1;
    @(negedge clk);
    chk("t6_busy_after", 32'(clr_busy), 0);
    chk("t6_wr_after", 32'(mem_wr), 0);
    tick();
    a_req = 1; a_wr = 0; a_addr = 4'd3;
    b_req = 1; b_wr = 0; b_addr = 4'd0;
    @(negedge clk);
    chk("t6_tie_a", 32'(a_gnt), 1);
    chk("t6_tie_b", 32'(b_gnt), 0);
    tick();
    a_req = 0; b_req = 0;
    @(negedge clk);
    chk("t6_rvalid", 32'(a_rvalid), 1);
    chk("t6_rdata", 32'(rdata), 0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
